// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial IF/MEM bus arbiter; define MEM_ARB_RR_EN for round-robin grant
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_len,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              own_d_q, own_d_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        step_q, step_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        dout_q, dout_d;
    logic              wr_q, wr_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              grant_d;
    logic [2:0]        len_n;
    logic [1:0]        cap_idx;
    logic [ADDR_W-1:0] step_ext;
`ifdef MEM_ARB_RR_EN
    logic              prefer_if_q, prefer_if_d;
`endif

`ifdef MEM_ARB_RR_EN
    assign grant_d = d_req && (!if_req || !prefer_if_q);
`else
    assign grant_d = d_req;
`endif

    assign step_ext = {{(ADDR_W-3){1'b0}}, step_q};
    // Byte captured at step s belongs to the address issued at step s-2.
    assign cap_idx  = step_q[1:0] - 2'd2;

    always_comb begin
        case (d_len)
            2'b00:   len_n = 3'd1;
            2'b01:   len_n = 3'd2;
            default: len_n = 3'd4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        n_d       = n_q;
        step_d    = step_q;
        wdata_d   = wdata_q;
        asm_d     = asm_q;
        ram_a_d   = ram_a_q;
        dout_d    = dout_q;
        wr_d      = wr_q;
        if_done_d = 1'b0;
        d_done_d  = 1'b0;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        prefer_if_d = prefer_if_q;
`endif
        case (state_q)
            IDLE: begin
                ram_a_d = '0;
                dout_d  = 8'h00;
                wr_d    = 1'b0;
                if (if_req || d_req) begin
                    own_d_d = grant_d;
                    addr_d  = grant_d ? d_addr : if_addr;
                    n_d     = grant_d ? len_n : 3'd4;
                    we_d    = grant_d & d_we;
                    wdata_d = d_wdata;
                    asm_d   = 32'h0;
                    step_d  = 3'd1;
                    ram_a_d = addr_d;
`ifdef MEM_ARB_RR_EN
                    prefer_if_d = grant_d;
`endif
                    if (we_d) begin
                        dout_d  = d_wdata[7:0];
                        wr_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                ram_a_d = (step_q < n_q) ? addr_q + step_ext : '0;
                if (step_q >= 3'd2)
                    asm_d[{cap_idx, 3'b000} +: 8] = ram_din;
                if (step_q == n_q + 3'd1) begin
                    state_d   = DONE;
                    if_done_d = ~own_d_q;
                    d_done_d  = own_d_q;
                    if (own_d_q) d_rdata_d = asm_d;
                    else         if_data_d = asm_d;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            WRITE: begin
                if (step_q < n_q) begin
                    ram_a_d = addr_q + step_ext;
                    dout_d  = wdata_q[{step_q[1:0], 3'b000} +: 8];
                    wr_d    = 1'b1;
                    step_d  = step_q + 3'd1;
                end else begin
                    ram_a_d   = '0;
                    dout_d    = 8'h00;
                    wr_d      = 1'b0;
                    state_d   = DONE;
                    if_done_d = ~own_d_q;
                    d_done_d  = own_d_q;
                end
            end
            DONE: begin
                if_data_d = 32'h0;
                d_rdata_d = 32'h0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            n_q       <= 3'd0;
            step_q    <= 3'd0;
            wdata_q   <= 32'h0;
            asm_q     <= 32'h0;
            ram_a_q   <= '0;
            dout_q    <= 8'h00;
            wr_q      <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if_data_q <= 32'h0;
            d_rdata_q <= 32'h0;
`ifdef MEM_ARB_RR_EN
            prefer_if_q <= 1'b0;
`endif
        end else if (rdy) begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            step_q    <= step_d;
            wdata_q   <= wdata_d;
            asm_q     <= asm_d;
            ram_a_q   <= ram_a_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            if_done_q <= if_done_d;
            d_done_q  <= d_done_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            prefer_if_q <= prefer_if_d;
`endif
        end
    end

    // A paused cycle must never strobe a write; the registers simply hold.
    assign ram_wr   = wr_q & rdy;
    assign ram_dout = ram_wr ? dout_q : 8'h00;
    assign ram_a    = ram_a_q;
    assign if_data  = if_data_q;
    assign if_done  = if_done_q;
    assign d_rdata  = d_rdata_q;
    assign d_done   = d_done_q;
endmodule
